// File: rtl/pool_requant_pkg.sv
// Shared definitions for the pooling/requantization output path:
// default activation width, saturation limit and the map-control state encoding.
package pool_requant_pkg;

   localparam int OUT_W_DEF = 8;
   localparam int SAT_MAX   = (1 << OUT_W_DEF) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pool_requant_requant_sat.sv
// Combinational requantizer: round-half-up right shift of an unsigned value,
// then unsigned saturation to an OUT_W-bit activation.
module requant_sat
   import pool_requant_pkg::*;
#(
   parameter int DATA_W = 25,
   parameter int OUT_W  = OUT_W_DEF
) (
   input  logic [DATA_W-1:0] i_m,
   input  logic [4:0]        i_shift,
   output logic [OUT_W-1:0]  o_q
);

   localparam logic [DATA_W:0] SAT_LIM = (DATA_W+1)'((1 << OUT_W) - 1);

   // One guard bit above DATA_W absorbs the rounding bias without overflow.
   function automatic logic [OUT_W-1:0] round_sat(input logic [DATA_W-1:0] m,
                                                  input logic [4:0]        sh);
      logic [DATA_W:0] bias;
      logic [DATA_W:0] sum;
      logic [DATA_W:0] r;
      bias = (sh == 5'd0) ? '0 : ({{DATA_W{1'b0}}, 1'b1} << (sh - 5'd1));
      sum  = {1'b0, m} + bias;
      r    = sum >> sh;
      if (r > SAT_LIM)
         return {OUT_W{1'b1}};
      return r[OUT_W-1:0];
   endfunction

   assign o_q = round_sat(i_m, i_shift);

endmodule

// File: rtl/pool_requant.sv
// 2x2 stride-2 max pooling over a row-major psum stream with a half-row line
// buffer, followed by rounding requantization to an 8-bit activation.
module pool_requant
   import pool_requant_pkg::*;
#(
   parameter int DATA_W = 25,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int MAX_W  = 64,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_width,
   input  logic [ADDR_W-1:0] cfg_height,
   input  logic [4:0]        cfg_shift,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int LB_D  = MAX_W / 2;
   localparam int LB_AW = $clog2(LB_D);

   state_t            r_state;
   logic [ADDR_W-1:0] r_w;
   logic [ADDR_W-1:0] r_h;
   logic [4:0]        r_shift;
   logic [ADDR_W-1:0] r_col;
   logic [ADDR_W-1:0] r_row;
   logic [DATA_W-1:0] r_hold;
   logic [DATA_W-1:0] r_lbuf [LB_D];
   logic              r_vld_p1;
   logic [OUT_W-1:0]  r_data_p1;
   logic              r_last_p1;
   logic              r_busy;
   logic              r_done;

   logic              w_acc;
   logic [DATA_W-1:0] w_x;
   logic [LB_AW-1:0]  w_lb_idx;
   logic [DATA_W-1:0] w_max_hx;
   logic [DATA_W-1:0] w_max_all;
   logic [OUT_W-1:0]  w_q;
   logic              w_col_end;
   logic              w_last_beat;
   logic [ADDR_W-1:0] w_last_pair_row;
   logic [ADDR_W-1:0] w_last_pair_col;
   logic              w_emit;
   logic              w_emit_last;

   function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Stage p0: accepted beat, clamp, window max against hold and line buffer
   assign w_acc     = (r_state == ST_RUN) && in_valid;
   assign w_x       = in_data[DATA_W-1] ? '0 : in_data;
   assign w_lb_idx  = r_col[LB_AW:1];
   assign w_max_hx  = umax(r_hold, w_x);
   assign w_max_all = umax(w_max_hx, r_lbuf[w_lb_idx]);

   assign w_col_end       = (r_col == r_w - ADDR_W'(1));
   assign w_last_beat     = w_col_end && (r_row == r_h - ADDR_W'(1));
   assign w_last_pair_row = {r_h[ADDR_W-1:1], 1'b0} - ADDR_W'(1);
   assign w_last_pair_col = {r_w[ADDR_W-1:1], 1'b0} - ADDR_W'(1);
   assign w_emit          = w_acc && r_row[0] && r_col[0];
   assign w_emit_last     = w_emit && (r_row == w_last_pair_row) &&
                            (r_col == w_last_pair_col);

   requant_sat #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W)
   ) u_requant (
      .i_m     (w_max_all),
      .i_shift (r_shift),
      .o_q     (w_q)
   );

   // Line buffer holds the even-row pair maxima; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_acc && !r_row[0] && r_col[0])
         r_lbuf[w_lb_idx] <= w_max_hx;
   end

   // Stage p1: registered pooled output and map control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_w       <= '0;
         r_h       <= '0;
         r_shift   <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_hold    <= '0;
         r_vld_p1  <= 1'b0;
         r_data_p1 <= '0;
         r_last_p1 <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_vld_p1  <= w_emit;
         r_last_p1 <= w_emit_last;
         if (w_emit)
            r_data_p1 <= w_q;
         if (w_acc && !r_col[0])
            r_hold <= w_x;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_w     <= cfg_width;
                  r_h     <= cfg_height;
                  r_shift <= cfg_shift;
                  r_col   <= '0;
                  r_row   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_acc) begin
                  if (w_last_beat) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
                  if (w_col_end) begin
                     r_col <= '0;
                     r_row <= r_row + ADDR_W'(1);
                  end else begin
                     r_col <= r_col + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_vld_p1;
   assign out_data  = r_data_p1;
   assign out_last  = r_last_p1;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_pool_requant.sv
// Directed and randomized bench for pool_requant with a window-level reference model.
module tb_pool_requant;

   localparam int DW = 25;
   localparam int OW = 8;
   localparam int MW = 64;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] cfg_width = '0;
   logic [AW-1:0] cfg_height = '0;
   logic [4:0]    cfg_shift = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;

   int n_assert = 0;
   int n_fail   = 0;
   int pix [4096];
   int got_q [$];
   int ref_q [$];

   pool_requant #(.DATA_W(DW), .OUT_W(OW), .MAX_W(MW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .cfg_shift  (cfg_shift),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input longint expv);
      n_assert++;
      assert (got === 64'(expv)) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic longint clampv(input int v);
      return (v >= (1 << 24)) ? 0 : longint'(v);
   endfunction

   // Reference: max of the clamped 2x2 window, rounded division by 2^sh, clipped to 255.
   function automatic int ref_pool(input int w, input int r, input int c, input int sh);
      longint m, p, q;
      m = clampv(pix[(r-1)*w + c-1]);
      if (clampv(pix[(r-1)*w + c]) > m) m = clampv(pix[(r-1)*w + c]);
      if (clampv(pix[r*w + c-1]) > m)   m = clampv(pix[r*w + c-1]);
      if (clampv(pix[r*w + c]) > m)     m = clampv(pix[r*w + c]);
      p = longint'(1) << sh;
      q = (m + p / 2) / p;
      return (q > 255) ? 255 : int'(q);
   endfunction

   task automatic run_map(input int w, input int h, input int sh, input int gap_pct,
                          input int abort_after, input int stray_at);
      int  idx, r, c;
      bit  emit;
      got_q.delete();
      cfg_width  = AW'(w);
      cfg_height = AW'(h);
      cfg_shift  = 5'(sh);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_width  = AW'($urandom_range(2, 60));
      cfg_height = AW'($urandom_range(2, 60));
      cfg_shift  = 5'($urandom_range(0, 24));
      chk("busy_after_start", busy, 1);
      idx = 0;
      while (idx < w * h) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            @(posedge clk); #1;
            chk("bubble_valid", out_valid, 0);
            chk("bubble_done", done, 0);
            continue;
         end
         r = idx / w;
         c = idx % w;
         in_valid = 1'b1;
         in_data  = DW'(pix[idx]);
         start    = (idx == stray_at);
         @(posedge clk); #1;
         in_valid = 1'b0;
         start    = 1'b0;
         emit = (r % 2 == 1) && (c % 2 == 1);
         chk("out_valid", out_valid, emit);
         if (emit) begin
            chk("out_data", out_data, ref_pool(w, r, c, sh));
            chk("out_last", out_last, (r == 2*(h/2) - 1) && (c == 2*(w/2) - 1));
            got_q.push_back(int'(out_data));
         end
         chk("done", done, idx == w*h - 1);
         idx++;
         if (idx == abort_after) begin
            rst_n = 1'b0;
            #2;
            chk("abort_valid", out_valid, 0);
            chk("abort_data", out_data, 0);
            chk("abort_last", out_last, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
               in_valid = 1'b1;
               in_data  = DW'(k + 1);
               @(posedge clk); #1;
               in_valid = 1'b0;
               chk("abort_no_done", done, 0);
               chk("abort_no_valid", out_valid, 0);
               chk("abort_idle_busy", busy, 0);
            end
            return;
         end
      end
      @(posedge clk); #1;
      chk("done_clear", done, 0);
      chk("busy_clear", busy, 0);
      chk("valid_clear", out_valid, 0);
   endtask

   task automatic chk_list(input string tag, input int expv [$]);
      chk({tag, "_count"}, got_q.size(), expv.size());
      for (int i = 0; i < expv.size() && i < got_q.size(); i++)
         chk(tag, got_q[i], expv[i]);
   endtask

   initial begin
      int w, h, sh;

      // Reset state
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = DW'(77);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("idle_ignores_valid", out_valid, 0);
      chk("idle_busy", busy, 0);

      // 4x4 ramp
      for (int i = 0; i < 16; i++) pix[i] = i + 1;
      run_map(4, 4, 0, 0, -1, -1);
      chk_list("ramp4x4", '{6, 8, 14, 16});

      // Rounding and saturation
      pix[0] = 100; pix[1] = 20; pix[2] = 35; pix[3] = 7;
      run_map(2, 2, 4, 0, -1, -1);
      chk_list("round", '{6});
      pix[0] = 32'h1000; pix[1] = 1; pix[2] = 2; pix[3] = 3;
      run_map(2, 2, 0, 0, -1, -1);
      chk_list("saturate", '{255});

      // Negative clamp
      pix[0] = 32'h1FFFFFF; pix[1] = 3; pix[2] = 1; pix[3] = 2;
      run_map(2, 2, 0, 0, -1, -1);
      chk_list("clamp", '{3});

      // Gapped vs gap-free on the same 4x2 data
      for (int i = 0; i < 8; i++) pix[i] = int'($urandom_range(0, 400));
      run_map(4, 2, 1, 0, -1, -1);
      ref_q = got_q;
      run_map(4, 2, 1, 40, -1, -1);
      chk_list("gapped", ref_q);

      // Odd dimensions
      for (int i = 0; i < 15; i++) pix[i] = i + 1;
      run_map(5, 3, 0, 0, -1, -1);
      chk_list("odd5x3", '{7, 9});

      // Full-width line buffer and maximum shift
      for (int i = 0; i < 128; i++) pix[i] = int'($urandom_range(0, 32'h1FFFFFF));
      run_map(64, 2, 24, 10, -1, -1);
      run_map(64, 2, 16, 0, -1, -1);

      // Randomized maps
      for (int t = 0; t < 8; t++) begin
         w  = int'($urandom_range(2, 12));
         h  = int'($urandom_range(2, 7));
         sh = int'($urandom_range(0, 12));
         for (int i = 0; i < w * h; i++)
            pix[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'h1FFFFFF))
                                                 : int'($urandom_range(0, 3000));
         run_map(w, h, sh, 20, -1, -1);
      end

      // Abort mid-map, then a clean rerun with a stray start during RUN
      for (int i = 0; i < 16; i++) pix[i] = i + 1;
      run_map(4, 4, 0, 0, 5, -1);
      run_map(4, 4, 0, 0, -1, 3);
      chk_list("after_abort", '{6, 8, 14, 16});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pool_requant.md
Name: pool_requant

Overview:
- Streaming stage directly downstream of the conv partial-sum buffer.
- Consumes the ReLU'd 25-bit accumulated output pixels, valid-qualified and in row-major order.
- Performs 2x2 stride-2 max pooling using a half-row line buffer, then requantizes with a rounding right shift and unsigned saturation to an 8-bit activation.
- Emits a valid-qualified pooled stream to the output feature-map writer.

Parameters:
- data_width, 25, width of incoming partial sum.
- out_width, 8, width of requantized output activation.
- max_width, 64, maximum feature-map row width in pixels; line buffer depth is max_width/2.
- addr_width, 7, width of the row/column counters; must satisfy 2^addr_width > max_width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches the cfg_* inputs and begins a map. Honoured only in IDLE.
- cfg_width  in  addr_width  input row width in pixels, 2..max_width.
- cfg_height  in  addr_width  input rows, >=2.
- cfg_shift  in  5  requant right-shift amount, 0..24.
- in_valid  in  1  in_data valid this cycle; there is no backpressure.
- in_data  in  data_width  psum pixel, treated as unsigned; MSB set is clamped to 0.
- out_valid  out  1  pooled pixel valid.
- out_data  out  out_width  requantized pooled pixel.
- out_last  out  1  with out_valid, marks the final pooled pixel of the map.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the map is complete.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, done=0; state=IDLE; counters=0; hold register=0. The line buffer is not reset.
- States and transitions:
  - IDLE -> RUN on start; cfg_* latched into registers, col=row=0.
  - RUN -> DONE when the beat at row==H-1, col==W-1 is accepted.
  - DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
- Gating:
  - in_valid is ignored outside RUN.
  - start is ignored outside IDLE.
  - cfg_* changes after start have no effect.
- Counters: advance only on an accepted beat (RUN & in_valid). col wraps W-1 -> 0 and increments row.
- Clamp: x = in_data[data_width-1] ? 0 : in_data.
- Even row (row[0]=0):
  - col even: hold <= x.
  - col odd: linebuf[col>>1] <= max(hold, x).
- Odd row (row[0]=1):
  - col even: hold <= x.
  - col odd: m = max(hold, x, linebuf[col>>1]).
  - Registered output the next cycle: out_valid=1, out_data=requant(m).
- Latency: exactly 1 cycle from the accepted beat to out_valid. Outputs are never stalled.
- Requant:
  - r = (m + (cfg_shift? 1<<(cfg_shift-1) : 0)) >> cfg_shift, computed at data_width+1 bits with no overflow.
  - out_data = r > 2^out_width-1 ? 2^out_width-1 : r[out_width-1:0].
- Odd dimensions: a trailing odd column or odd final row is consumed but produces no output.
- out_last: set with the output of the last complete 2x2 window (row==2*floor(H/2)-1, col==2*floor(W/2)-1).
- done timing: done asserts the cycle after the final input beat, coincident with out_valid/out_last when the final beat produces output.
- Line buffer: register array with combinational read. The write in an even row and the read in the following odd row never collide within a cycle.
- Back-to-back maps: a new start is accepted in the cycle after done.
- Async reset mid-map: aborts immediately. Outputs and state go to reset values; no done is issued.

Decomposition:
- Shared package: out_width default, the state encoding (IDLE/RUN/DONE), and the sat_max constant 2^out_width-1.
- One natural sub-module: requant_sat (combinational round/shift/saturate). It is reused later by other output paths.
- Line buffer, counters and FSM stay in pool_requant.

Test Plan:
- 4x4 map, shift=0, row-major inputs 1..16 -> 4 outputs {6,8,14,16}, each 1 cycle after beats 6,8,14,16; out_last with 16; done pulse coincident.
- 2x2 map, shift=4, inputs {100,20,35,7} -> single output 6 (100+8=108, >>4=6); with input 0x1000 and shift=0 -> out_data=255 (saturation).
- Negative clamp: 2x2 map, inputs {0x1FFFFFF,3,1,2}, shift=0 -> output 3.
- Gapped valid: 4x2 map with random in_valid bubbles -> output values identical to the gap-free run; out_valid only 1 cycle after qualifying beats; no spurious outputs during bubbles.
- Odd dimensions: 5x3 map, inputs 1..15 -> outputs {7,9} only; out_last with 9; done the cycle after beat 15.
- rst_n pulled low after beat 5 of a 4x4 map -> all outputs 0 and no done. A fresh start followed by 1..16 reproduces {6,8,14,16}; start during RUN is ignored.
